// File: rtl/player_motion_ctrl.sv
// Per-player motion/state engine: turns buttons into x/y/pose/hp once per frame.
// Hits are handled on any cycle; everything else advances on i_frame_tick.
module player_motion_ctrl #(
  parameter int PLAYER_ID  = 1,
  parameter int INIT_X     = -200,
  parameter int LIMIT_X    = 300,
  parameter int STEP_X     = 6,
  parameter int V          = 8,
  parameter int MAX_J      = 32,
  parameter int HP_MAX     = 7,
  parameter int INV_FRAMES = 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_jump,
  input  logic        i_squat,
  input  logic        i_shield,
  input  logic        i_hit,
  input  logic        i_restart,
  output logic [11:0] o_x,
  output logic [5:0]  o_y,
  output logic [3:0]  o_pose,
  output logic        o_facing,
  output logic [2:0]  o_hp,
  output logic        o_invuln,
  output logic        o_dead
);

  localparam int INV_W = $clog2(INV_FRAMES + 1);

  typedef enum logic [2:0] {
    S_GROUND = 3'd0,
    S_AIR    = 3'd1,
    S_SQUAT  = 3'd2,
    S_SHIELD = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  localparam logic [3:0]        POSE_BASE = (PLAYER_ID == 2) ? 4'd4 : 4'd1;
  localparam logic [11:0]       X_INIT    = INIT_X[11:0];
  localparam logic signed [12:0] X_LIM_P  = LIMIT_X[12:0];
  localparam logic signed [12:0] X_LIM_N  = -X_LIM_P;
  localparam logic signed [12:0] X_STEP   = STEP_X[12:0];
  localparam logic signed [7:0]  Y_MAX    = MAX_J[7:0];
  localparam logic [5:0]        V_TAKEOFF = V[5:0];
  localparam logic [2:0]        HP_INIT   = HP_MAX[2:0];
  localparam logic [INV_W-1:0]  INV_LOAD  = INV_FRAMES[INV_W-1:0];

  state_t             state_q, state_d;
  logic signed [11:0] x_q, x_d;
  logic [5:0]         y_q, y_d;
  logic signed [5:0]  v_q, v_d;
  logic               facing_q, facing_d;
  logic [2:0]         hp_q, hp_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic               invuln_q, invuln_d;
  logic               dead_q, dead_d;
  logic [3:0]         pose_q, pose_d;
  logic               jprev_q, jprev_d;

  // Shared decode of the current cycle's events
  logic              jump_edge, hit_ok, kill;
  logic [2:0]        hp_hit;
  logic signed [7:0] air_sum;
  logic              land;
  logic signed [12:0] x_walk;

  assign jump_edge = i_jump & ~jprev_q;
  assign hit_ok    = i_hit && (state_q != S_SHIELD) && (state_q != S_DEAD) && (inv_q == '0);
  assign hp_hit    = (hp_q == 3'd0) ? 3'd0 : hp_q - 3'd1;
  assign kill      = hit_ok && (hp_hit == 3'd0);
  assign air_sum   = $signed({2'b00, y_q}) + $signed({{2{v_q[5]}}, v_q});
  assign land      = (air_sum <= 8'sd0);

  // Walking target with saturation at +/-LIMIT_X; both or neither button holds position
  always_comb begin
    x_walk = {x_q[11], x_q};
    if (i_right && !i_left) begin
      x_walk = {x_q[11], x_q} + X_STEP;
      if (x_walk > X_LIM_P) x_walk = X_LIM_P;
    end else if (i_left && !i_right) begin
      x_walk = {x_q[11], x_q} - X_STEP;
      if (x_walk < X_LIM_N) x_walk = X_LIM_N;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_GROUND;
    else          state_q <= state_d;
  end

  // FSM next state: restart beats a lethal hit, which beats the per-frame transition
  always_comb begin
    state_d = state_q;
    if (i_restart) begin
      state_d = S_GROUND;
    end else if (kill) begin
      state_d = S_DEAD;
    end else if (i_frame_tick) begin
      case (state_q)
        S_GROUND: begin
          if (jump_edge)     state_d = S_AIR;
          else if (i_shield) state_d = S_SHIELD;
          else if (i_squat)  state_d = S_SQUAT;
        end
        S_AIR:    if (land)      state_d = S_GROUND;
        S_SQUAT:  if (!i_squat)  state_d = S_GROUND;
        S_SHIELD: if (!i_shield) state_d = S_GROUND;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs: pose follows the next state, frozen once dead
  always_comb begin
    pose_d = POSE_BASE;
    case (state_d)
      S_SHIELD: pose_d = POSE_BASE + 4'd1;
      S_SQUAT:  pose_d = POSE_BASE + 4'd2;
      S_DEAD:   pose_d = pose_q;
      default:  pose_d = POSE_BASE;
    endcase
    if (i_restart) pose_d = POSE_BASE;
  end

  // Datapath next values: motion on ticks, hit bookkeeping on any cycle
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    v_d      = v_q;
    facing_d = facing_q;
    hp_d     = hp_q;
    inv_d    = inv_q;
    dead_d   = dead_q;
    jprev_d  = i_frame_tick ? i_jump : jprev_q;
    if (i_restart) begin
      x_d      = X_INIT;
      y_d      = 6'd0;
      v_d      = 6'sd0;
      facing_d = 1'b1;
      hp_d     = HP_INIT;
      inv_d    = '0;
      dead_d   = 1'b0;
      jprev_d  = 1'b0;
    end else begin
      // A hit reloads the window and suppresses this tick's decrement
      if (hit_ok) begin
        hp_d  = hp_hit;
        inv_d = INV_LOAD;
      end else if (i_frame_tick && inv_q != '0) begin
        inv_d = inv_q - 1'b1;
      end
      if (kill) dead_d = 1'b1;
      // Motion is frozen in DEAD and on the cycle a hit kills
      if (i_frame_tick && !kill && state_q != S_DEAD) begin
        if (state_q == S_GROUND || state_q == S_AIR) begin
          x_d = x_walk[11:0];
          if (i_right ^ i_left) facing_d = i_right;
        end
        if (state_q == S_GROUND && jump_edge) begin
          y_d = V_TAKEOFF;
          v_d = $signed(V_TAKEOFF - 6'd1);
        end else if (state_q == S_AIR) begin
          if (land) begin
            y_d = 6'd0;
            v_d = 6'sd0;
          end else begin
            y_d = (air_sum > Y_MAX) ? Y_MAX[5:0] : air_sum[5:0];
            v_d = v_q - 6'sd1;
          end
        end
      end
    end
    invuln_d = (inv_d != '0);
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q      <= X_INIT;
      y_q      <= 6'd0;
      v_q      <= 6'sd0;
      facing_q <= 1'b1;
      hp_q     <= HP_INIT;
      inv_q    <= '0;
      invuln_q <= 1'b0;
      dead_q   <= 1'b0;
      pose_q   <= POSE_BASE;
      jprev_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      v_q      <= v_d;
      facing_q <= facing_d;
      hp_q     <= hp_d;
      inv_q    <= inv_d;
      invuln_q <= invuln_d;
      dead_q   <= dead_d;
      pose_q   <= pose_d;
      jprev_q  <= jprev_d;
    end
  end

  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_pose   = pose_q;
  assign o_facing = facing_q;
  assign o_hp     = hp_q;
  assign o_invuln = invuln_q;
  assign o_dead   = dead_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl (player 1 defaults).
module tb_player_motion_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_frame_tick = 1'b0;
  logic        i_left = 1'b0, i_right = 1'b0, i_jump = 1'b0;
  logic        i_squat = 1'b0, i_shield = 1'b0, i_hit = 1'b0, i_restart = 1'b0;
  logic [11:0] o_x;
  logic [5:0]  o_y;
  logic [3:0]  o_pose;
  logic        o_facing;
  logic [2:0]  o_hp;
  logic        o_invuln;
  logic        o_dead;

  int checks = 0;
  int failures = 0;

  player_motion_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_tick(i_frame_tick),
    .i_left(i_left), .i_right(i_right), .i_jump(i_jump), .i_squat(i_squat),
    .i_shield(i_shield), .i_hit(i_hit), .i_restart(i_restart),
    .o_x(o_x), .o_y(o_y), .o_pose(o_pose), .o_facing(o_facing),
    .o_hp(o_hp), .o_invuln(o_invuln), .o_dead(o_dead)
  );

  always #5 i_clk = ~i_clk;

  // Stimulus changes on the falling edge; outputs are read there too.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk) i_frame_tick = 1'b1;
      @(negedge i_clk) i_frame_tick = 1'b0;
    end
  endtask

  task automatic hit_pulse();
    @(negedge i_clk) i_hit = 1'b1;
    @(negedge i_clk) i_hit = 1'b0;
  endtask

  task automatic restart();
    @(negedge i_clk);
    {i_left, i_right, i_jump, i_squat, i_shield, i_hit} = '0;
    i_restart = 1'b1;
    @(negedge i_clk) i_restart = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ($signed(o_x) !== -12'sd200) begin failures++; $display("FAIL reset_x got=%0d exp=-200", $signed(o_x)); end
    checks++; if (o_y !== 6'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", o_y); end
    checks++; if (o_pose !== 4'd1) begin failures++; $display("FAIL reset_pose got=%0d exp=1", o_pose); end
    checks++; if (o_hp !== 3'd7) begin failures++; $display("FAIL reset_hp got=%0d exp=7", o_hp); end
    checks++; if ({o_dead, o_invuln, o_facing} !== 3'b001) begin failures++; $display("FAIL reset_flags got=%b exp=001", {o_dead, o_invuln, o_facing}); end
  endtask

  task automatic test_walk();
    i_right = 1'b1;
    repeat (4) @(negedge i_clk);
    checks++; if ($signed(o_x) !== -12'sd200) begin failures++; $display("FAIL no_tick_move got=%0d exp=-200", $signed(o_x)); end
    tick(3);
    checks++; if ($signed(o_x) !== -12'sd182 || o_facing !== 1'b1) begin failures++; $display("FAIL walk_right got=%0d/%b exp=-182/1", $signed(o_x), o_facing); end
    i_right = 1'b0; i_left = 1'b1; tick(1);
    checks++; if ($signed(o_x) !== -12'sd188 || o_facing !== 1'b0) begin failures++; $display("FAIL walk_left got=%0d/%b exp=-188/0", $signed(o_x), o_facing); end
    i_right = 1'b1; tick(1);
    checks++; if ($signed(o_x) !== -12'sd188 || o_facing !== 1'b0) begin failures++; $display("FAIL walk_both got=%0d/%b exp=-188/0", $signed(o_x), o_facing); end
    i_left = 1'b0; tick(81);
    checks++; if ($signed(o_x) !== 12'sd298) begin failures++; $display("FAIL walk_298 got=%0d exp=298", $signed(o_x)); end
    tick(1);
    checks++; if ($signed(o_x) !== 12'sd300) begin failures++; $display("FAIL walk_clamp got=%0d exp=300", $signed(o_x)); end
    tick(2);
    checks++; if ($signed(o_x) !== 12'sd300) begin failures++; $display("FAIL walk_hold got=%0d exp=300", $signed(o_x)); end
    restart();
    i_left = 1'b1; tick(17);
    checks++; if ($signed(o_x) !== -12'sd300) begin failures++; $display("FAIL walk_clamp_neg got=%0d exp=-300", $signed(o_x)); end
    restart();
  endtask

  task automatic test_jump();
    int exp_y [17] = '{8, 15, 21, 26, 30, 32, 32, 32, 32, 31, 29, 26, 22, 17, 11, 4, 0};
    i_jump = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick(1);
      checks++; if (int'(o_y) !== exp_y[k]) begin failures++; $display("FAIL jump_y[%0d] got=%0d exp=%0d", k, o_y, exp_y[k]); end
    end
    tick(2);
    checks++; if (o_y !== 6'd0) begin failures++; $display("FAIL jump_held_rejump got=%0d exp=0", o_y); end
    i_jump = 1'b0; tick(1); i_jump = 1'b1; i_right = 1'b1; tick(1);
    checks++; if (o_y !== 6'd8 || $signed(o_x) !== -12'sd194) begin failures++; $display("FAIL jump_regrab got=%0d/%0d exp=8/-194", o_y, $signed(o_x)); end
    // Hit in the air: hp drops, trajectory keeps going
    hit_pulse(); i_right = 1'b0; tick(1);
    checks++; if (o_y !== 6'd15 || o_hp !== 3'd6) begin failures++; $display("FAIL jump_hit got=%0d/%0d exp=15/6", o_y, o_hp); end
    restart();
  endtask

  task automatic test_shield_squat();
    i_shield = 1'b1; tick(2);
    hit_pulse();
    checks++; if (o_pose !== 4'd2 || o_hp !== 3'd7 || o_invuln !== 1'b0) begin failures++; $display("FAIL shield_hit got=%0d/%0d/%b exp=2/7/0", o_pose, o_hp, o_invuln); end
    i_shield = 1'b0; tick(1);
    checks++; if (o_pose !== 4'd1) begin failures++; $display("FAIL shield_release got=%0d exp=1", o_pose); end
    i_squat = 1'b1; tick(1);
    i_right = 1'b1; tick(1);
    checks++; if (o_pose !== 4'd3 || $signed(o_x) !== -12'sd200) begin failures++; $display("FAIL squat_still got=%0d/%0d exp=3/-200", o_pose, $signed(o_x)); end
    i_squat = 1'b0; i_right = 1'b0; tick(1);
    checks++; if (o_pose !== 4'd1) begin failures++; $display("FAIL squat_release got=%0d exp=1", o_pose); end
    restart();
  endtask

  task automatic test_hits();
    hit_pulse();
    checks++; if (o_hp !== 3'd6 || o_invuln !== 1'b1) begin failures++; $display("FAIL hit1 got=%0d/%b exp=6/1", o_hp, o_invuln); end
    tick(5); hit_pulse();
    checks++; if (o_hp !== 3'd6) begin failures++; $display("FAIL hit_invuln got=%0d exp=6", o_hp); end
    tick(25);
    checks++; if (o_invuln !== 1'b0) begin failures++; $display("FAIL invuln_expire got=%b exp=0", o_invuln); end
    // Hit coincident with tick: reload wins, no decrement on that tick
    @(negedge i_clk) begin i_hit = 1'b1; i_frame_tick = 1'b1; end
    @(negedge i_clk) begin i_hit = 1'b0; i_frame_tick = 1'b0; end
    checks++; if (o_hp !== 3'd5 || o_invuln !== 1'b1) begin failures++; $display("FAIL hit_tick got=%0d/%b exp=5/1", o_hp, o_invuln); end
    tick(29);
    checks++; if (o_invuln !== 1'b1) begin failures++; $display("FAIL invuln_29 got=%b exp=1", o_invuln); end
    tick(1);
    checks++; if (o_invuln !== 1'b0) begin failures++; $display("FAIL invuln_30 got=%b exp=0", o_invuln); end
    restart();
  endtask

  task automatic test_dead();
    for (int k = 0; k < 7; k++) begin
      hit_pulse();
      if (k < 6) tick(31);
    end
    checks++; if (o_hp !== 3'd0 || o_dead !== 1'b1) begin failures++; $display("FAIL dead got=%0d/%b exp=0/1", o_hp, o_dead); end
    i_right = 1'b1; i_jump = 1'b1; i_shield = 1'b1; tick(3);
    hit_pulse(); tick(1);
    checks++; if ($signed(o_x) !== -12'sd200 || o_y !== 6'd0 || o_pose !== 4'd1 || o_hp !== 3'd0 || o_dead !== 1'b1)
      begin failures++; $display("FAIL dead_frozen got x=%0d y=%0d pose=%0d hp=%0d dead=%b", $signed(o_x), o_y, o_pose, o_hp, o_dead); end
    restart();
    checks++; if ($signed(o_x) !== -12'sd200 || o_y !== 6'd0 || o_pose !== 4'd1 || o_hp !== 3'd7 || {o_dead, o_invuln, o_facing} !== 3'b001)
      begin failures++; $display("FAIL restart got x=%0d y=%0d pose=%0d hp=%0d flags=%b", $signed(o_x), o_y, o_pose, o_hp, {o_dead, o_invuln, o_facing}); end
  endtask

  task automatic test_async_reset();
    i_jump = 1'b1; tick(4);
    checks++; if (o_y !== 6'd26) begin failures++; $display("FAIL prereset_y got=%0d exp=26", o_y); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_y !== 6'd0 || o_hp !== 3'd7 || $signed(o_x) !== -12'sd200) begin failures++; $display("FAIL async_reset got y=%0d hp=%0d x=%0d", o_y, o_hp, $signed(o_x)); end
    @(negedge i_clk) i_rst_n = 1'b1;
    tick(1);
    checks++; if (o_y !== 6'd8) begin failures++; $display("FAIL post_reset_jump got=%0d exp=8", o_y); end
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    test_reset();
    test_walk();
    test_jump();
    test_shield_squat();
    test_hits();
    test_dead();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
